// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the multiply/divide sequencer.
//   master (EX stage): start, op, a, b, rd_in, kill   -> sequencer
//   slave  (sequencer): stall, busy, done, result, rd_out -> EX stage
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            kill;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, a, b, rd_in, kill,
    input  stall, busy, done, result, rd_out
  );

  modport slave (
    input  start, op, a, b, rd_in, kill,
    output stall, busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide engine with its sequencing FSM.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle; the result sign is applied in the final step.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - muldiv_sequencer_if.slave (start/op/a/b/rd_in/kill in,
//            stall/busy/done/result/rd_out out)
// Optional build macro: MULDIV_FAST_PATH_EN -- trivial operands (b == 0,
// a == 0 for multiply, b == 1 for unsigned ops) skip iteration and finish in
// one cycle with identical results.
//
// state  | meaning
// IDLE   | waiting for start
// MUL    | shift-add multiply iterating, counter counts down to 0
// DIV    | restoring divide iterating, counter counts down to 0
// DONE   | done pulse, result/rd_out valid; accepts a new start
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  counter;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic            a_neg, b_neg, res_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    a_neg = bus.a[XLEN-1] & ((bus.op == 3'd1) || (bus.op == 3'd2) ||
                             (bus.op == 3'd4) || (bus.op == 3'd6));
    b_neg = bus.b[XLEN-1] & ((bus.op == 3'd1) || (bus.op == 3'd4) ||
                             (bus.op == 3'd6));
    mag_a = a_neg ? -bus.a : bus.a;
    mag_b = b_neg ? -bus.b : bus.b;
    case (bus.op)
      3'd1, 3'd2: res_neg = a_neg ^ b_neg;
      // A zero divisor must give all-ones quotient regardless of dividend sign.
      3'd4:       res_neg = (a_neg ^ b_neg) & (bus.b != '0);
      3'd6:       res_neg = a_neg;
      default:    res_neg = 1'b0;
    endcase
  end

  // acc holds {high, low} of the product for multiply, {remainder, quotient}
  // for divide (quotient bits shift in as dividend bits shift out).
  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, quo_rem, final_res;
  logic [2*XLEN-1:0] acc_next, prod_fix;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a_q} : '0);
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_ge   = div_sh >= {1'b0, mag_b_q};
    div_diff = div_sh[XLEN-1:0] - mag_b_q;
    if (state == S_MUL)
      acc_next = {mul_sum, acc[XLEN-1:1]};
    else
      acc_next = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    prod_fix = neg_q ? -acc_next : acc_next;
    quo_rem  = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (!op_q[2])
      final_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      final_res = neg_q ? -quo_rem : quo_rem;
  end

`ifdef MULDIV_FAST_PATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (bus.b == '0) begin
      fast_hit = 1'b1;
      fast_res = !bus.op[2] ? '0 : (bus.op[1] ? bus.a : '1);
    end else if (!bus.op[2] && (bus.a == '0)) begin
      fast_hit = 1'b1;
    end else if ((bus.b == XLEN'(1)) &&
                 ((bus.op == 3'd3) || (bus.op == 3'd5) || (bus.op == 3'd7))) begin
      fast_hit = 1'b1;
      fast_res = (bus.op == 3'd5) ? bus.a : '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc      <= '0;
      counter  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (bus.kill) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            rd_q    <= bus.rd_in;
            neg_q   <= res_neg;
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            acc     <= {{XLEN{1'b0}}, (bus.op[2] ? mag_a : mag_b)};
            counter <= CNT_W'(XLEN - 1);
`ifdef MULDIV_FAST_PATH_EN
            if (fast_hit) begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              result_q <= fast_res;
              rd_out_q <= bus.rd_in;
            end else begin
              state  <= bus.op[2] ? S_DIV : S_MUL;
              busy_q <= 1'b1;
            end
`else
            state  <= bus.op[2] ? S_DIV : S_MUL;
            busy_q <= 1'b1;
`endif
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          acc <= acc_next;
          if (counter == '0) begin
            state    <= S_DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= final_res;
            rd_out_q <= rd_q;
          end else begin
            counter <= counter - 1'b1;
          end
        end
      endcase
    end
  end

  // The start term lets the issuing instruction hold EX in the same cycle.
  assign bus.stall  = (state == S_MUL) || (state == S_DIV) ||
                      (bus.start && ((state == S_IDLE) || (state == S_DONE)) && !bus.kill);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;
`ifdef MULDIV_FAST_PATH_EN
  localparam int LAT_Z = 1;
`else
  localparam int LAT_Z = XLEN + 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   next_rd  = 1;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge (cycle 0); returns at #1 in the cycle
  // after the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat, input string tag);
    int   n;
    logic stall_ok;
    logic [4:0] rd;
    rd = 5'(next_rd);
    next_rd++;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.rd_in = rd;
    @(negedge clk);
    check($sformatf("%s_stall_c0", tag), 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!bus.done && !bus.stall) stall_ok = 1'b0;
    end while (!bus.done && n < 60);
    check($sformatf("%s_lat", tag), 32'(n), 32'(lat));
    check($sformatf("%s_res", tag), bus.result, exp);
    check($sformatf("%s_rd", tag), 32'(bus.rd_out), 32'(rd));
    check($sformatf("%s_stall_busy", tag), 32'(stall_ok), 32'd1);
    check($sformatf("%s_stall_done", tag), 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 60);
  endtask

  initial begin
    int  n;
    logic seen;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0; bus.kill = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall",  32'(bus.stall),  32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", bus.result,      32'd0);
    check("rst_rd",     32'(bus.rd_out), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT,   "mul");
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT,   "mulh");
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT,   "mulhu");
    do_op(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT,   "mulhsu");
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT,   "div");
    do_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT,   "rem");
    do_op(3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF, LAT_Z, "divu_z");
    do_op(3'd7, 32'h00001234, 32'd0,        32'h00001234, LAT_Z, "remu_z");
    do_op(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, LAT_Z, "div_z");
    do_op(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_Z, "rem_z");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT,   "div_ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT,   "rem_ovf");

    // Back-to-back: start held through done; mid-flight input changes ignored.
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.rd_in = 5'd3;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1 bus.a = 32'd1000; bus.op = 3'd7;
    wait_done(n);
    check("b2b_mul_lat",   32'(n + 4),      32'd33);
    check("b2b_mul_res",   bus.result,      32'd15);
    check("b2b_mul_rd",    32'(bus.rd_out), 32'd3);
    check("b2b_mul_stall", 32'(bus.stall),  32'd1);
    bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7; bus.rd_in = 5'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(n);
    check("b2b_divu_lat", 32'(n),          32'd33);
    check("b2b_divu_res", bus.result,      32'd14);
    check("b2b_divu_rd",  32'(bus.rd_out), 32'd9);
    @(posedge clk); #1;

    // kill in cycle 10 of a DIV.
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd200; bus.b = 32'd3; bus.rd_in = 5'd12;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1 bus.kill = 1'b0;
    @(negedge clk);
    check("kill_stall", 32'(bus.stall), 32'd0);
    check("kill_busy",  32'(bus.busy),  32'd0);
    seen = bus.done;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("kill_no_done", 32'(seen),       32'd0);
    check("kill_result",  bus.result,      32'd14);
    check("kill_rd",      32'(bus.rd_out), 32'd9);
    @(posedge clk); #1;

    // kill wins over start in the same cycle.
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    check("killprio_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1 bus.start = 1'b0; bus.kill = 1'b0;
    @(negedge clk);
    check("killprio_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-MUL.
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.rd_in = 5'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_stall",  32'(bus.stall),  32'd0);
    check("arst_busy",   32'(bus.busy),   32'd0);
    check("arst_done",   32'(bus.done),   32'd0);
    check("arst_result", bus.result,      32'd0);
    check("arst_rd",     32'(bus.rd_out), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_op(3'd0, 32'd6, 32'd7, 32'd42, LAT, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
